// File: rtl/posit_defines_es3_pkg.sv
// Shared definitions for the 32-bit ES=3 posit datapath.
//   NBITS          posit word width
//   ES             exponent field size
//   MULT_LAT_ES3   start->done latency of the ES=3 multiplier, in cycles
//   CNT_W          width of the buffer occupancy / credit counters (0..64)
//   posit_result_t one multiplier result: posit bits plus inf / zero flags
package posit_defines_es3;

  localparam int NBITS        = 32;
  localparam int ES           = 3;
  localparam int MULT_LAT_ES3 = 4;
  localparam int CNT_W        = 7;

  typedef struct packed {
    logic [NBITS-1:0] bits;
    logic             inf;
    logic             zero;
  } posit_result_t;

endpackage

// File: rtl/posit_mult_result_buffer_es3_fifo.sv
// Synchronous show-ahead FIFO with a registered head.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data this cycle (dropped and flagged on overflow when full)
//   pop         consume the head; ignored while head_valid is low
//   head_valid  head holds an unread entry
//   head        registered head entry; holds the last popped entry while empty
//   occupancy   entries stored, 0..DEPTH
//   overflow    single-cycle pulse: push attempted while full
module posit_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8,
  parameter int  CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output logic             head_valid,
  output T                 head,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] occ_q, occ_nxt;
  logic             valid_q;
  T                 head_q;
  logic             full, push_ok, pop_ok, bypass;

  assign full     = (occ_q == CNT_W'(DEPTH));
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & valid_q;
  assign overflow = push & full;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    occ_nxt    = occ_q;
    rd_ptr_nxt = rd_ptr_q;
    if (pop_ok) rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   occ_nxt = occ_q + CNT_W'(1);
      2'b01:   occ_nxt = occ_q - CNT_W'(1);
      default: ;
    endcase
  end

  // The entry that becomes head next cycle is being written right now (empty
  // FIFO, or one entry left and it is being popped): take it from push_data.
  assign bypass = push_ok & (wr_ptr_q == rd_ptr_nxt);

  // NOTE: storage is deliberately not reset; only the pointers and valid
  // state are, and no entry is ever read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_q <= rd_ptr_nxt;
      occ_q    <= occ_nxt;
      valid_q  <= (occ_nxt != '0);
      if (occ_nxt != '0) head_q <= bypass ? push_data : mem[rd_ptr_nxt];
    end
  end

  assign head_valid = valid_q;
  assign head       = head_q;
  assign occupancy  = occ_q;

endmodule

// File: rtl/posit_mult_result_buffer_es3.sv
// Result buffer behind the fixed-latency ES=3 posit multiplier.
// Issues are credited against free FIFO space so a result is never dropped;
// results leave in issue order on a valid/ready stream.
//   req_valid/req_ready   upstream operand handshake; mult_start = issue
//   mult_done/result/inf/zero   multiplier return path
//   out_valid/out_ready/out_*   registered result stream
//   occupancy, in_flight  stored entries / issued-but-not-returned operations
//   err_spurious          sticky: unexpected done, or push into a full FIFO
module posit_mult_result_buffer_es3
  import posit_defines_es3::*;
#(
  parameter int DEPTH    = 8,
  parameter int MULT_LAT = MULT_LAT_ES3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             mult_start,
  input  logic             mult_done,
  input  logic [NBITS-1:0] mult_result,
  input  logic             mult_inf,
  input  logic             mult_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_result,
  output logic             out_inf,
  output logic             out_zero,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] in_flight,
  output logic             err_spurious
);

  localparam int BLANK_W  = $clog2(MULT_LAT + 2);
  localparam int CREDIT_W = CNT_W + 1;

  logic [BLANK_W-1:0]  blank_q;
  logic [CNT_W-1:0]    in_flight_q;
  logic                err_q;
  logic                blanked, issue, done_live, done_ok, done_bad, overflow;
  logic [CREDIT_W-1:0] credit_sum;
  posit_result_t       push_data, head;

  // The multiplier has no reset, so an operation started before reset can
  // still complete; its done is ignored until the blanking counter expires.
  assign blanked = (blank_q != '0);

  // Same-cycle pops are not credited, keeping req_ready off the out_ready path.
  assign credit_sum = CREDIT_W'(occupancy) + CREDIT_W'(in_flight_q);
  assign req_ready  = ~blanked & (credit_sum < CREDIT_W'(DEPTH));
  assign issue      = req_valid & req_ready;
  assign mult_start = issue;

  assign done_live = mult_done & ~blanked;
  assign done_ok   = done_live & (in_flight_q != '0);
  assign done_bad  = done_live & (in_flight_q == '0);
  assign push_data = '{bits: mult_result, inf: mult_inf, zero: mult_zero};

  posit_sync_fifo #(
    .T     (posit_result_t),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (done_ok),
    .push_data  (push_data),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head       (head),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q     <= BLANK_W'(MULT_LAT);
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (blanked) blank_q <= blank_q - BLANK_W'(1);
      case ({issue, done_ok})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: ;
      endcase
      if (done_bad | overflow) err_q <= 1'b1;
    end
  end

  assign in_flight    = in_flight_q;
  assign err_spurious = err_q;
  assign out_result   = head.bits;
  assign out_inf      = head.inf;
  assign out_zero     = head.zero;

`ifndef SYNTHESIS
  credit_invariant: assert property (@(posedge clk) disable iff (!rst_n)
    credit_sum <= CREDIT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_posit_mult_result_buffer_es3.sv
module tb_posit_mult_result_buffer_es3;
  import posit_defines_es3::*;

  localparam int DEPTH    = 8;
  localparam int MULT_LAT = MULT_LAT_ES3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready, mult_start, mult_done, mult_inf, mult_zero;
  logic [NBITS-1:0] mult_result, out_result;
  logic             out_valid, out_inf, out_zero, err_spurious;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] occupancy, in_flight;

  always #5 clk = ~clk;

  posit_mult_result_buffer_es3 #(.DEPTH(DEPTH), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mult_start(mult_start), .mult_done(mult_done), .mult_result(mult_result),
    .mult_inf(mult_inf), .mult_zero(mult_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_inf(out_inf),
    .out_zero(out_zero), .occupancy(occupancy), .in_flight(in_flight),
    .err_spurious(err_spurious)
  );

  int n_checks = 0, n_fail = 0, issue_cnt = 0, inv_viol = 0;
  posit_result_t sb_q[$];
  posit_result_t stim_q[$];
  logic          drv_en = 1'b0, force_done = 1'b0, iss_pend = 1'b0;
  posit_result_t force_res = '0, cur_exp = '0, iss_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h", name, act, exp);
    end
  endtask

  function automatic posit_result_t mk(logic [31:0] b, logic i, logic z);
    posit_result_t r;
    r.bits = b; r.inf = i; r.zero = z;
    return r;
  endfunction

  // Product of a posit with 1.0 (0x40000000): the operand itself, with 0
  // flagged zero and NaR (0x80000000) flagged inf.
  function automatic posit_result_t times_one(logic [31:0] a);
    return mk(a, a == 32'h8000_0000, a == 32'h0000_0000);
  endfunction

  // Stand-in for the fixed-latency multiplier: carries the hand-computed
  // product of each issued operand pair through MULT_LAT stages, no reset.
  logic [MULT_LAT-1:0] pipe_v = '0;
  posit_result_t       pipe_d [MULT_LAT];
  posit_result_t       mult_bundle;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MULT_LAT-2:0], iss_pend};
    pipe_d[0] <= iss_data;
    for (int i = 1; i < MULT_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign mult_done   = pipe_v[MULT_LAT-1] | force_done;
  assign mult_bundle = force_done ? force_res : pipe_d[MULT_LAT-1];
  assign mult_result = mult_bundle.bits;
  assign mult_inf    = mult_bundle.inf;
  assign mult_zero   = mult_bundle.zero;

  // Request driver: presents the head of stim_q while drv_en is set.
  always @(posedge clk) begin
    #2;
    req_valid = drv_en && (stim_q.size() != 0);
    if (stim_q.size() != 0) cur_exp = stim_q[0];
  end

  // Issue observer: an issue commits at the coming edge; record its expected result.
  always @(negedge clk) begin
    iss_pend = rst_n && req_valid && req_ready;
    if (iss_pend) begin
      iss_data = cur_exp;
      sb_q.push_back(cur_exp);
      void'(stim_q.pop_front());
      issue_cnt++;
    end
  end

  // Output monitor: compares every popped entry against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: actual pop of %h, expected no output",
                 {out_result, out_inf, out_zero});
      end else begin
        check("sb_order", {out_result, out_inf, out_zero}, sb_q.pop_front());
      end
    end
    if (rst_n && (int'(occupancy) + int'(in_flight) > DEPTH)) inv_viol++;
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || stim_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, sb_q.size() + stim_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_err", err_spurious, 0);
    check("rst_out", {out_result, out_inf, out_zero}, 0);

    // Blanking window with req_valid held and stray done pulses, then 1.0 x 1.0
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_done = 1'b1;
    force_res = mk(32'hDEAD_BEEF, 1'b0, 1'b0);
    stim_q.push_back(times_one(32'h4000_0000));
    drv_en = 1'b1;
    for (int k = 0; k < MULT_LAT; k++) begin
      @(negedge clk);
      check("blank_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    force_done = 1'b0;
    @(negedge clk);
    check("ready_after_blank", req_ready, 1);
    check("blank_err", err_spurious, 0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      @(negedge clk);
      check("lat_no_valid", out_valid, 0);
    end
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_result", {out_result, out_inf, out_zero}, mk(32'h4000_0000, 1'b0, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_one", 50);
    check("occupancy_after_one", occupancy, 0);

    // Fill with out_ready low: exactly DEPTH issues, then one pop frees a credit
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = issue_cnt;
    for (int i = 0; i < DEPTH + 1; i++) stim_q.push_back(times_one(32'h4100_0000 + i));
    repeat (20) @(negedge clk);
    check("fill_issues", issue_cnt - base, DEPTH);
    check("fill_ready", req_ready, 0);
    check("fill_occupancy", occupancy, DEPTH);
    check("fill_in_flight", in_flight, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pop_ready", req_ready, 1);
    check("pop_occupancy", occupancy, DEPTH - 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_fill", 100);
    check("fill_total_issues", issue_cnt - base, DEPTH + 1);

    // Special operands: 0 x 0x50000000 -> zero; NaR x 1.0 -> inf
    @(posedge clk); #1;
    stim_q.push_back(mk(32'h0000_0000, 1'b0, 1'b1));
    stim_q.push_back(mk(32'h8000_0000, 1'b1, 1'b0));
    wait_drain("drain_special", 50);
    @(negedge clk);
    check("empty_valid", out_valid, 0);
    check("hold_after_empty", {out_result, out_inf, out_zero}, mk(32'h8000_0000, 1'b1, 1'b0));

    // Spurious done after blanking with nothing in flight
    @(posedge clk); #1;
    force_res = mk(32'h1234_5678, 1'b0, 1'b0);
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    @(negedge clk);
    check("spurious_err", err_spurious, 1);
    check("spurious_occupancy", occupancy, 0);
    check("spurious_in_flight", in_flight, 0);
    repeat (5) @(negedge clk);
    check("spurious_sticky", err_spurious, 1);
    check("spurious_no_valid", out_valid, 0);

    // Random-issue stream with a reset pulse part way through
    for (int i = 0; i < 1000; i++) begin
      if (i % 97 == 0)      stim_q.push_back(times_one(32'h0000_0000));
      else if (i % 89 == 0) stim_q.push_back(times_one(32'h8000_0000));
      else                  stim_q.push_back(times_one($urandom()));
    end
    cyc = 0;
    while (stim_q.size() != 0 && cyc < 20000) begin
      @(posedge clk); #1;
      drv_en = 1'($urandom_range(0, 1));
      cyc++;
      if (cyc == 600) begin
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("midrst_occupancy", occupancy, 0);
        check("midrst_in_flight", in_flight, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err", err_spurious, 0);
        check("midrst_out", {out_result, out_inf, out_zero}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    drv_en = 1'b1;
    wait_drain("drain_stream", 300);
    check("invariant_violations", inv_viol, 0);
    check("stream_err", err_spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
